// File: rtl/minisys_pkg.sv
// Shared definitions for the instruction fetch slice.
//   state_t     : fetch FSM encoding (IDLE / REQ / HOLD)
//   flow_t      : decoded flow-control flags of the held instruction
//   EXC_VECTOR  : exception redirect target
//   RESET_PC    : PC value while reset is asserted
//   branch_offset() : sign-extended, word-scaled 16-bit branch displacement
package minisys_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_HOLD = 2'd2;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_F000;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  typedef struct packed {
    logic jmp;
    logic jal;
    logic jalr;
    logic jrn;
    logic beq;
    logic bne;
    logic bgez;
    logic bgtz;
    logic blez;
    logic bltz;
    logic bgezal;
    logic bltzal;
    logic eret;
  } flow_t;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and memory (slave).
// One request outstanding at a time: imem_req/imem_addr are held until the
// memory answers with imem_valid/imem_rdata.
//   imem_req   : fetch request
//   imem_addr  : fetch address
//   imem_rdata : fetched word
//   imem_valid : imem_rdata valid this cycle
interface ifetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC and branch-condition logic for the held instruction.
//   pc, instr_index : PC and low 26 bits of the held instruction
//   flow            : decoded flow-control flags
//   rs_data/rt_data : register operands (compared as signed values)
//   epc, exc_req    : exception return address / exception redirect
//   npc             : next fetch address
//   pc4             : PC+4 (link value)
//   link            : the instruction writes link_addr when consumed
//   misalign        : register-jump target had non-zero low bits
module npc_calc
  import minisys_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  input  flow_t       flow,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] epc,
  input  logic        exc_req,
  output logic [31:0] npc,
  output logic [31:0] pc4,
  output logic        link,
  output logic        misalign
);

  logic rs_neg;
  logic rs_zero;
  logic taken;

  // NOTE: every output of this block gets a default at the top so no path
  // through the if/else chain can leave a value unassigned (no latches).
  always_comb begin
    pc4      = pc + 32'd4;
    npc      = pc4;
    misalign = 1'b0;
    rs_neg   = rs_data[31];
    rs_zero  = (rs_data == 32'd0);

    taken = (flow.beq && (rs_data == rt_data))
         || (flow.bne && (rs_data != rt_data))
         || ((flow.bgez || flow.bgezal) && !rs_neg)
         || (flow.bgtz && !rs_neg && !rs_zero)
         || (flow.blez && (rs_neg || rs_zero))
         || ((flow.bltz || flow.bltzal) && rs_neg);

    if (exc_req) begin
      npc = EXC_VECTOR;
    end else if (flow.eret) begin
      npc = epc;
    end else if (flow.jrn || flow.jalr) begin
      // Low bits are dropped so the fetch stays word-aligned; flag it.
      npc      = {rs_data[31:2], 2'b00};
      misalign = |rs_data[1:0];
    end else if (flow.jmp || flow.jal) begin
      npc = {pc4[31:28], instr_index, 2'b00};
    end else if (taken) begin
      npc = pc4 + branch_offset(instr_index[15:0]);
    end

    // Conditional links write the return address whether or not taken;
    // an exception pre-empts the instruction, so nothing is linked then.
    link = !exc_req && (flow.jal || flow.jalr || flow.bgezal || flow.bltzal);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: fetches one word at a time over the imem bus,
// holds it for decode, and computes the next PC when it is consumed.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   imem              : instruction memory bus (master side)
//   Instruction/PC    : held instruction word and its address
//   inst_valid        : Instruction is valid
//   dec_ready, stall  : consumption happens on dec_ready && !stall
//   Jmp..Bltzal, Eret : decoded flow-control flags of the held instruction
//   rs_data, rt_data  : register operands of the held instruction
//   exc_req, epc      : exception redirect / Eret return address
//   link_addr         : PC+4 of the last linking instruction
//   misalign          : one-cycle pulse on a misaligned register-jump target
module ifetch_unit
  import minisys_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  ifetch_unit_if.master       imem,
  output logic [31:0]         Instruction,
  output logic                inst_valid,
  input  logic                dec_ready,
  input  logic                stall,
  output logic [31:0]         PC,
  output logic [31:0]         link_addr,
  input  logic                Jmp,
  input  logic                Jal,
  input  logic                Jalr,
  input  logic                Jrn,
  input  logic                Beq,
  input  logic                Bne,
  input  logic                Bgez,
  input  logic                Bgtz,
  input  logic                Blez,
  input  logic                Bltz,
  input  logic                Bgezal,
  input  logic                Bltzal,
  input  logic                Eret,
  input  logic [31:0]         rs_data,
  input  logic [31:0]         rt_data,
  input  logic                exc_req,
  input  logic [31:0]         epc,
  output logic                misalign
);

  state_t      state;
  logic        exc_pend;
  flow_t       flow;
  logic        consume;
  logic [31:0] npc;
  logic [31:0] pc4;
  logic        npc_link;
  logic        npc_misalign;

  assign flow = '{jmp: Jmp, jal: Jal, jalr: Jalr, jrn: Jrn, beq: Beq, bne: Bne,
                  bgez: Bgez, bgtz: Bgtz, blez: Blez, bltz: Bltz,
                  bgezal: Bgezal, bltzal: Bltzal, eret: Eret};

  // An exception forces consumption even when decode is not ready or stalled.
  assign consume = (state == S_HOLD) && ((dec_ready && !stall) || exc_req);

  assign imem.imem_req  = (state == S_REQ);
  assign imem.imem_addr = PC;

  npc_calc u_npc_calc (
    .pc          (PC),
    .instr_index (Instruction[25:0]),
    .flow        (flow),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .epc         (epc),
    .exc_req     (exc_req),
    .npc         (npc),
    .pc4         (pc4),
    .link        (npc_link),
    .misalign    (npc_misalign)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      PC          <= RESET_PC;
      Instruction <= 32'd0;
      inst_valid  <= 1'b0;
      link_addr   <= 32'd0;
      misalign    <= 1'b0;
      exc_pend    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (exc_req) PC <= EXC_VECTOR;
          state <= S_REQ;
        end
        S_REQ: begin
          if (imem.imem_valid) begin
            // An exception raised while the request was in flight (or in the
            // same cycle as the reply) drops the word and refetches from the
            // vector; the bus stays in REQ for that new fetch.
            if (exc_pend || exc_req) begin
              PC       <= EXC_VECTOR;
              exc_pend <= 1'b0;
            end else begin
              Instruction <= imem.imem_rdata;
              inst_valid  <= 1'b1;
              state       <= S_HOLD;
            end
          end else if (exc_req) begin
            exc_pend <= 1'b1;
          end
        end
        S_HOLD: begin
          if (consume) begin
            PC         <= npc;
            inst_valid <= 1'b0;
            misalign   <= npc_misalign;
            state      <= S_REQ;
            if (npc_link) link_addr <= pc4;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a reset/first-fetch sequence, a table of
// held-instruction vectors (steered into place with Eret), and hand-written
// sequences for exceptions in flight, stalls, stray memory replies and
// resets during a request.
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Instruction;
  logic        inst_valid;
  logic        dec_ready;
  logic        stall;
  logic [31:0] PC;
  logic [31:0] link_addr;
  logic        Jmp, Jal, Jalr, Jrn, Beq, Bne, Bgez, Bgtz, Blez, Bltz;
  logic        Bgezal, Bltzal, Eret;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        exc_req;
  logic [31:0] epc;
  logic        misalign;

  ifetch_unit_if imem_bus();

  ifetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .imem        (imem_bus),
    .Instruction (Instruction),
    .inst_valid  (inst_valid),
    .dec_ready   (dec_ready),
    .stall       (stall),
    .PC          (PC),
    .link_addr   (link_addr),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jalr        (Jalr),
    .Jrn         (Jrn),
    .Beq         (Beq),
    .Bne         (Bne),
    .Bgez        (Bgez),
    .Bgtz        (Bgtz),
    .Blez        (Blez),
    .Bltz        (Bltz),
    .Bgezal      (Bgezal),
    .Bltzal      (Bltzal),
    .Eret        (Eret),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .exc_req     (exc_req),
    .epc         (epc),
    .misalign    (misalign)
  );

  always #5 clock = ~clock;

  // Flag masks, MSB first: Jmp Jal Jalr Jrn Beq Bne Bgez Bgtz Blez Bltz Bgezal Bltzal Eret
  localparam logic [12:0] F_NONE   = 13'h0000;
  localparam logic [12:0] F_JMP    = 13'h1000;
  localparam logic [12:0] F_JAL    = 13'h0800;
  localparam logic [12:0] F_JALR   = 13'h0400;
  localparam logic [12:0] F_JRN    = 13'h0200;
  localparam logic [12:0] F_BEQ    = 13'h0100;
  localparam logic [12:0] F_BNE    = 13'h0080;
  localparam logic [12:0] F_BGEZ   = 13'h0040;
  localparam logic [12:0] F_BGTZ   = 13'h0020;
  localparam logic [12:0] F_BLEZ   = 13'h0010;
  localparam logic [12:0] F_BLTZ   = 13'h0008;
  localparam logic [12:0] F_BGEZAL = 13'h0004;
  localparam logic [12:0] F_BLTZAL = 13'h0002;
  localparam logic [12:0] F_ERET   = 13'h0001;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [12:0] fl;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        dr;
    logic        st;
    logic        exc;
    logic [31:0] epc;
    logic [31:0] exp_npc;
    logic [31:0] exp_link;
    logic        exp_mis;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic set_flags(input logic [12:0] f);
    {Jmp, Jal, Jalr, Jrn, Beq, Bne, Bgez, Bgtz, Blez, Bltz, Bgezal, Bltzal, Eret} = f;
  endtask

  // Wait (bounded) for a request, reply after 'lat' request cycles.
  task automatic fetch(input logic [31:0] word, input int lat, output logic [31:0] addr);
    int n = 0;
    while (!imem_bus.imem_req && n < 20) begin
      step();
      n++;
    end
    check("req_wait", 32'(imem_bus.imem_req), 32'd1);
    addr = imem_bus.imem_addr;
    for (int i = 1; i < lat; i++) step();
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = word;
    step();
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'd0;
  endtask

  function automatic vec_t mk(input logic [31:0] word, pc, input logic [12:0] fl,
                              input logic [31:0] rs, rt, input logic dr, st, exc,
                              input logic [31:0] ep, exp_npc, exp_link, input logic exp_mis);
    vec_t v;
    v.word = word; v.pc = pc; v.fl = fl; v.rs = rs; v.rt = rt;
    v.dr = dr; v.st = st; v.exc = exc; v.epc = ep;
    v.exp_npc = exp_npc; v.exp_link = exp_link; v.exp_mis = exp_mis;
    return v;
  endfunction

  vec_t vt[19];

  initial begin
    logic [31:0] a;

    //            word          pc            flags               rs            rt       dr  st  exc epc     npc           link          mis
    vt[0]  = mk(32'h1500fffe, 32'h00000018, F_BNE,            32'h1,        32'h0,     1, 0, 0, 32'h0,  32'h00000014, 32'h00000000, 0);
    vt[1]  = mk(32'h1500fffe, 32'h00000018, F_BNE,            32'h5,        32'h5,     1, 0, 0, 32'h0,  32'h0000001c, 32'h00000000, 0);
    vt[2]  = mk(32'h0c000000, 32'h00000040, F_JAL,            32'h0,        32'h0,     1, 0, 0, 32'h0,  32'h00000000, 32'h00000044, 0);
    vt[3]  = mk(32'h08000054, 32'h00000100, F_JMP,            32'h0,        32'h0,     1, 0, 0, 32'h0,  32'h00000150, 32'h00000044, 0);
    vt[4]  = mk(32'h00600008, 32'h00000200, F_JRN,            32'h00000103, 32'h0,     1, 0, 0, 32'h0,  32'h00000100, 32'h00000044, 1);
    vt[5]  = mk(32'h10220004, 32'h00001000, F_BEQ,            32'h7,        32'h7,     1, 0, 0, 32'h0,  32'h00001014, 32'h00000044, 0);
    vt[6]  = mk(32'h04210003, 32'h00002000, F_BGEZ,           32'h0,        32'h0,     1, 0, 0, 32'h0,  32'h00002010, 32'h00000044, 0);
    vt[7]  = mk(32'h1c200005, 32'h00003000, F_BGTZ,           32'h0,        32'h0,     1, 0, 0, 32'h0,  32'h00003004, 32'h00000044, 0);
    vt[8]  = mk(32'h18200002, 32'h00003000, F_BLEZ,           32'h80000000, 32'h0,     1, 0, 0, 32'h0,  32'h0000300c, 32'h00000044, 0);
    vt[9]  = mk(32'h0420ffff, 32'h00000500, F_BLTZ,           32'h1,        32'h0,     1, 0, 0, 32'h0,  32'h00000504, 32'h00000044, 0);
    vt[10] = mk(32'h0430fffc, 32'h00000800, F_BLTZAL,         32'hffffffff, 32'h0,     1, 0, 0, 32'h0,  32'h000007f4, 32'h00000804, 0);
    vt[11] = mk(32'h04310004, 32'h00000900, F_BGEZAL,         32'hffffffff, 32'h0,     1, 0, 0, 32'h0,  32'h00000904, 32'h00000904, 0);
    vt[12] = mk(32'h0060f809, 32'h00000a00, F_JALR,           32'h00001234, 32'h0,     1, 0, 0, 32'h0,  32'h00001234, 32'h00000a04, 0);
    vt[13] = mk(32'h0060f809, 32'h00000b00, F_JALR,           32'h00002002, 32'h0,     1, 0, 0, 32'h0,  32'h00002000, 32'h00000b04, 1);
    vt[14] = mk(32'h00000000, 32'hfffffffc, F_NONE,           32'h0,        32'h0,     1, 0, 0, 32'h0,  32'h00000000, 32'h00000b04, 0);
    vt[15] = mk(32'h08000004, 32'h40000010, F_JMP,            32'h0,        32'h0,     1, 0, 0, 32'h0,  32'h40000010, 32'h00000b04, 0);
    vt[16] = mk(32'h1500fffe, 32'h00000600, F_BNE,            32'h1,        32'h0,     0, 1, 1, 32'h0,  32'h0000f000, 32'h00000b04, 0);
    vt[17] = mk(32'h42000018, 32'h00000700, F_ERET | F_JRN,   32'h00000100, 32'h0,     1, 0, 0, 32'h24, 32'h00000024, 32'h00000b04, 0);
    vt[18] = mk(32'h1c20fff0, 32'h00000080, F_BGTZ,           32'h5,        32'h0,     1, 0, 0, 32'h0,  32'h00000044, 32'h00000b04, 0);

    reset = 1'b1;
    dec_ready = 1'b0;
    stall = 1'b0;
    set_flags(F_NONE);
    rs_data = 32'd0;
    rt_data = 32'd0;
    exc_req = 1'b0;
    epc = 32'd0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'd0;

    // Reset state and first fetch with 1-cycle memory latency.
    repeat (3) step();
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_pc", PC, 32'd0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_ivalid", 32'(inst_valid), 32'd0);
    check("rst_link", link_addr, 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    reset = 1'b0;
    step();
    check("first_req", 32'(imem_bus.imem_req), 32'd1);
    check("first_addr", imem_bus.imem_addr, 32'd0);
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = 32'h3c08ffff;
    step();
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    check("first_instr", Instruction, 32'h3c08ffff);
    check("first_ivalid", 32'(inst_valid), 32'd1);
    check("first_pc", PC, 32'd0);
    check("first_hold_req", 32'(imem_bus.imem_req), 32'd0);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("second_addr", imem_bus.imem_addr, 32'h4);
    check("second_ivalid", 32'(inst_valid), 32'd0);
    fetch(32'h00000000, 1, a);

    // Table: steer PC with Eret, fetch the vector word, consume it.
    for (int i = 0; i < 19; i++) begin
      set_flags(F_ERET);
      epc = vt[i].pc;
      dec_ready = 1'b1;
      step();
      set_flags(F_NONE);
      epc = 32'd0;
      dec_ready = 1'b0;
      fetch(vt[i].word, 1, a);
      check($sformatf("v%0d_steer", i), a, vt[i].pc);
      check($sformatf("v%0d_pc", i), PC, vt[i].pc);
      check($sformatf("v%0d_instr", i), Instruction, vt[i].word);
      set_flags(vt[i].fl);
      rs_data = vt[i].rs;
      rt_data = vt[i].rt;
      dec_ready = vt[i].dr;
      stall = vt[i].st;
      exc_req = vt[i].exc;
      epc = vt[i].epc;
      step();
      set_flags(F_NONE);
      rs_data = 32'd0;
      rt_data = 32'd0;
      dec_ready = 1'b0;
      stall = 1'b0;
      exc_req = 1'b0;
      epc = 32'd0;
      check($sformatf("v%0d_npc", i), imem_bus.imem_addr, vt[i].exp_npc);
      check($sformatf("v%0d_link", i), link_addr, vt[i].exp_link);
      check($sformatf("v%0d_mis", i), 32'(misalign), 32'(vt[i].exp_mis));
      fetch(32'h00000000, 1, a);
      check($sformatf("v%0d_mis_clr", i), 32'(misalign), 32'd0);
    end

    // Exception while a 3-cycle fetch is in flight, then Eret.
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("exc_req_addr", imem_bus.imem_addr, 32'h48);
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    step();
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = 32'hdeadbeef;
    step();
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    check("exc_ivalid", 32'(inst_valid), 32'd0);
    check("exc_still_req", 32'(imem_bus.imem_req), 32'd1);
    check("exc_addr", imem_bus.imem_addr, 32'h0000f000);
    fetch(32'h42000018, 1, a);
    set_flags(F_ERET);
    epc = 32'h24;
    dec_ready = 1'b1;
    step();
    set_flags(F_NONE);
    epc = 32'd0;
    dec_ready = 1'b0;
    check("eret_addr", imem_bus.imem_addr, 32'h24);

    // Five stalled cycles in HOLD; a stray memory reply is ignored.
    fetch(32'h8c010000, 1, a);
    dec_ready = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_bus.imem_valid = (i == 2);
      imem_bus.imem_rdata = 32'hbad0bad0;
      step();
      check($sformatf("stall%0d_instr", i), Instruction, 32'h8c010000);
      check($sformatf("stall%0d_pc", i), PC, 32'h24);
      check($sformatf("stall%0d_req", i), 32'(imem_bus.imem_req), 32'd0);
    end
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    stall = 1'b0;
    step();
    dec_ready = 1'b0;
    check("unstall_req", 32'(imem_bus.imem_req), 32'd1);
    check("unstall_addr", imem_bus.imem_addr, 32'h28);

    // Reset during REQ; a late reply in the IDLE cycle must be ignored.
    reset = 1'b1;
    step();
    check("rreq_req", 32'(imem_bus.imem_req), 32'd0);
    check("rreq_link", link_addr, 32'd0);
    reset = 1'b0;
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = 32'h12345678;
    step();
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    check("late_ivalid", 32'(inst_valid), 32'd0);
    check("late_instr", Instruction, 32'd0);
    check("late_req", 32'(imem_bus.imem_req), 32'd1);
    check("late_addr", imem_bus.imem_addr, 32'd0);

    // Exception in the IDLE cycle redirects the first fetch.
    reset = 1'b1;
    step();
    reset = 1'b0;
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    check("idle_exc_req", 32'(imem_bus.imem_req), 32'd1);
    check("idle_exc_addr", imem_bus.imem_addr, 32'h0000f000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these ports:
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to PC.
- imem_rdata  in  32  fetched word.
- imem_valid  in  1  imem_rdata valid; at most one request outstanding.
- Instruction  out  32  held instruction word presented to control32.
- inst_valid  out  1  Instruction is valid.
- dec_ready  in  1  decode stage consumes Instruction this cycle.
- stall  in  1  hazard hold; blocks consumption.
- PC  out  32  address of the held Instruction.
- link_addr  out  32  PC+4 of the last linking instruction.
- Jmp, Jal, Jalr, Jrn, Beq, Bne, Bgez, Bgtz, Blez, Bltz, Bgezal, Bltzal  in  1 each  decoded flow-control flags for the held Instruction.
- Eret  in  1  return from exception.
- rs_data, rt_data  in  32 each  register operands of the held Instruction.
- exc_req  in  1  exception redirect request.
- epc  in  32  return address used by Eret.
- misalign  out  1  one-cycle pulse on a misaligned Jrn/Jalr target.

Function
REQ-003 The block SHALL implement a 3-state FSM: IDLE, REQ, HOLD.
REQ-004 IDLE SHALL last exactly one cycle after reset and then move to REQ.
REQ-005 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal PC. On imem_valid the block SHALL latch imem_rdata into Instruction, set inst_valid=1 and move to HOLD.
REQ-006 In HOLD, the instruction SHALL be consumed only when dec_ready=1 and stall=0. Otherwise Instruction, PC and inst_valid SHALL hold.
REQ-007 On consumption the block SHALL load the next PC, clear inst_valid and move to REQ. Minimum issue interval is 2 cycles plus memory latency.
REQ-008 Next-PC priority (highest first):
- exc_req: EXC_VECTOR = 0x0000F000.
- Eret: epc.
- Jrn or Jalr: {rs_data[31:2],2'b00}.
- Jmp or Jal: {PC4[31:28], Instruction[25:0], 2'b00}.
- Taken branch: PC4 + (sign-extended Instruction[15:0] << 2).
- Otherwise: PC4.
PC4 = PC+4, modulo 2^32.
REQ-009 Branch-taken conditions, using signed rs_data and rt_data:
- Beq: rs == rt.
- Bne: rs != rt.
- Bgez and Bgezal: rs >= 0.
- Bgtz: rs > 0.
- Blez: rs <= 0.
- Bltz and Bltzal: rs < 0.
REQ-010 The architecture SHALL have no delay slot; the redirect takes effect on the very next fetch.
REQ-011 On consumption of Jal, Jalr, Bgezal or Bltzal, link_addr SHALL load PC4. Bgezal and Bltzal SHALL link whether taken or not.
REQ-012 On consumption of Jrn/Jalr with rs_data[1:0] != 0, misalign SHALL pulse for one cycle and the target SHALL be forced word-aligned.
REQ-013 exc_req SHALL be handled according to state:
- In HOLD: take effect at the next consumption opportunity, regardless of dec_ready and stall.
- In REQ: set a pending flag. When imem_valid returns, discard the word (inst_valid stays 0), set PC=EXC_VECTOR and remain in REQ.
- In IDLE: set PC=EXC_VECTOR.
REQ-014 PC wrap: 0xFFFFFFFC + 4 SHALL yield 0x00000000 with no error.
REQ-015 imem_valid arriving outside REQ SHALL be ignored.

Reset
REQ-016 While reset=1: state=IDLE, PC=0, Instruction=0, inst_valid=0, link_addr=0, imem_req=0, misalign=0, pending flag=0.
REQ-017 A reset asserted during REQ SHALL abandon the outstanding request. A late imem_valid SHALL be ignored per REQ-015.

Structure
REQ-018 A shared package minisys_pkg SHALL hold the FSM state typedef, EXC_VECTOR and RESET_PC.
REQ-019 Next-PC and branch-condition logic SHALL be a combinational sub-module npc_calc. The FSM and registers SHALL stay in ifetch_unit.

Verification
REQ-020 Reset, then memory with 1-cycle latency returning 0x3c08ffff at address 0 -> imem_req in the second cycle after reset, Instruction=0x3c08ffff, PC=0, next fetch address 0x4.
REQ-021 Held 0x1500fffe (Bne) at PC=0x18, rs=1, rt=0 -> next fetch address 0x14. With rs=rt -> 0x1c.
REQ-022 Held 0x0c000000 (Jal) at PC=0x40 -> next fetch address 0x0, link_addr=0x44. Held 0x08000054 (J) -> next fetch address 0x150.
REQ-023 exc_req during REQ with 3-cycle memory latency -> returned word dropped, inst_valid stays 0, next imem_addr=0xF000. Then Eret with epc=0x24 -> next fetch address 0x24.
REQ-024 stall=1 held for 5 cycles in HOLD -> Instruction and PC stable, no imem_req. After release with dec_ready=1 -> fetch of PC+4.
REQ-025 Jrn with rs_data=0x00000103 -> misalign pulse, next fetch address 0x100. Sequential fetch at PC=0xFFFFFFFC -> next fetch address 0x0.
